// File: rtl/kv_pkg.sv
// Shared types and constants for the key/value store arbiter.
package kv_pkg;

   localparam int KV_W        = 16;
   localparam int TIMEOUT_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } kv_state_e;

endpackage

// File: rtl/kv_rr_arbiter.sv
// Two-way round-robin picker: a lone requester wins; when both request,
// the port that did not win last time is chosen.
module kv_rr_arbiter (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/kv_arbiter.sv
// Arbitrates two requesters onto one key/value store port, with a WAIT
// timeout that aborts the store transaction and returns an error.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | no transaction; grant a requester when the store is free
//   ST_WAIT  | request presented on M_*, counting until ACK or timeout
//   ST_DRAIN | result returned; wait for the store to drop M_ACK_i
module kv_arbiter
   import kv_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic            sys_clk,
   input  logic            sys_rst_n,

   input  logic            R0_STB_i,
   input  logic            R0_WE_i,
   input  logic [KV_W-1:0] R0_ADR_i,
   input  logic [KV_W-1:0] R0_DAT_i,
   input  logic            R0_ADR_IS_KEY_i,
   input  logic            R0_DAT_IS_KEY_i,
   output logic            R0_ACK_o,
   output logic [KV_W-1:0] R0_DAT_o,
   output logic            R0_DUP_o,
   output logic            R0_ERR_o,
   output logic            R0_STALL_o,

   input  logic            R1_STB_i,
   input  logic            R1_WE_i,
   input  logic [KV_W-1:0] R1_ADR_i,
   input  logic [KV_W-1:0] R1_DAT_i,
   input  logic            R1_ADR_IS_KEY_i,
   input  logic            R1_DAT_IS_KEY_i,
   output logic            R1_ACK_o,
   output logic [KV_W-1:0] R1_DAT_o,
   output logic            R1_DUP_o,
   output logic            R1_ERR_o,
   output logic            R1_STALL_o,

   output logic            M_STB_o,
   output logic            M_CYC_o,
   output logic            M_WE_o,
   output logic            M_ADR_IS_KEY_o,
   output logic            M_DAT_IS_KEY_o,
   output logic [KV_W-1:0] M_ADR_o,
   output logic [KV_W-1:0] M_DAT_o,
   output logic            M_ABORT_o,
   input  logic            M_ACK_i,
   input  logic            M_DUP_i,
   input  logic            M_STALL_i,
   input  logic [KV_W-1:0] M_DAT_i
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]            rst_sync_q;
   logic                  ready;
   logic [1:0]            req;
   logic [1:0]            gnt;
   logic [1:0]            we_v, akey_v, dkey_v;
   logic [1:0][KV_W-1:0]  adr_v, dat_v;

   kv_state_e             state_q, state_d;
   logic                  last_grant_q;
   logic                  sel_q;
   logic [7:0]            cnt_q;
   logic                  do_grant, do_done, do_abort;

   logic [1:0]            ack_q, dup_q, err_q;
   logic [1:0][KV_W-1:0]  rdat_q;
   logic                  m_stb_q, m_cyc_q, m_we_q, m_akey_q, m_dkey_q, m_abort_q;
   logic [KV_W-1:0]       m_adr_q, m_dat_q;

   // Assertion is immediate; release reaches the grant logic two edges later.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) rst_sync_q <= 2'b00;
      else            rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign ready = rst_sync_q[1];

   assign req    = {R1_STB_i, R0_STB_i};
   assign we_v   = {R1_WE_i, R0_WE_i};
   assign akey_v = {R1_ADR_IS_KEY_i, R0_ADR_IS_KEY_i};
   assign dkey_v = {R1_DAT_IS_KEY_i, R0_DAT_IS_KEY_i};
   assign adr_v  = {R1_ADR_i, R0_ADR_i};
   assign dat_v  = {R1_DAT_i, R0_DAT_i};

   kv_rr_arbiter u_rr (
      .req        (req),
      .last_grant (last_grant_q),
      .gnt        (gnt)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      do_grant = 1'b0;
      do_done  = 1'b0;
      do_abort = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ready && (req != 2'b00) && !M_STALL_i) begin
               do_grant = 1'b1;
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // a store ACK in the timeout cycle still counts as completion
            if (M_ACK_i) begin
               do_done = 1'b1;
               state_d = ST_DRAIN;
            end else if (cnt_q == CNT_LAST) begin
               do_abort = 1'b1;
               state_d  = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!M_ACK_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         last_grant_q <= 1'b1;
         sel_q        <= 1'b0;
         cnt_q        <= 8'd0;
         ack_q        <= 2'b00;
         dup_q        <= 2'b00;
         err_q        <= 2'b00;
         rdat_q       <= '0;
         m_stb_q      <= 1'b0;
         m_cyc_q      <= 1'b0;
         m_we_q       <= 1'b0;
         m_akey_q     <= 1'b0;
         m_dkey_q     <= 1'b0;
         m_adr_q      <= '0;
         m_dat_q      <= '0;
         m_abort_q    <= 1'b0;
      end else begin
         ack_q     <= 2'b00;
         m_abort_q <= 1'b0;
         if (state_q == ST_WAIT && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
         if (do_grant) begin
            sel_q        <= gnt[1];
            last_grant_q <= gnt[1];
            cnt_q        <= 8'd0;
            m_stb_q      <= 1'b1;
            m_cyc_q      <= 1'b1;
            m_we_q       <= we_v[gnt[1]];
            m_akey_q     <= akey_v[gnt[1]];
            m_dkey_q     <= dkey_v[gnt[1]];
            m_adr_q      <= adr_v[gnt[1]];
            m_dat_q      <= dat_v[gnt[1]];
         end
         if (do_done) begin
            rdat_q[sel_q] <= M_DAT_i;
            dup_q[sel_q]  <= M_DUP_i;
            err_q[sel_q]  <= 1'b0;
            ack_q[sel_q]  <= 1'b1;
            m_stb_q       <= 1'b0;
            m_cyc_q       <= 1'b0;
         end
         if (do_abort) begin
            rdat_q[sel_q] <= '0;
            dup_q[sel_q]  <= 1'b0;
            err_q[sel_q]  <= 1'b1;
            ack_q[sel_q]  <= 1'b1;
            m_abort_q     <= 1'b1;
            m_stb_q       <= 1'b0;
            m_cyc_q       <= 1'b0;
         end
      end
   end

   // Stall is forced low while reset is held so every output reads zero.
   assign R0_STALL_o = sys_rst_n & ~(do_grant & gnt[0]);
   assign R1_STALL_o = sys_rst_n & ~(do_grant & gnt[1]);

   assign R0_ACK_o = ack_q[0];
   assign R0_DAT_o = rdat_q[0];
   assign R0_DUP_o = dup_q[0];
   assign R0_ERR_o = err_q[0];
   assign R1_ACK_o = ack_q[1];
   assign R1_DAT_o = rdat_q[1];
   assign R1_DUP_o = dup_q[1];
   assign R1_ERR_o = err_q[1];

   assign M_STB_o        = m_stb_q;
   assign M_CYC_o        = m_cyc_q;
   assign M_WE_o         = m_we_q;
   assign M_ADR_IS_KEY_o = m_akey_q;
   assign M_DAT_IS_KEY_o = m_dkey_q;
   assign M_ADR_o        = m_adr_q;
   assign M_DAT_o        = m_dat_q;
   assign M_ABORT_o      = m_abort_q;

endmodule

// File: tb/tb_kv_arbiter.sv
// Bench for kv_arbiter: the bench plays both requesters and the store,
// predicting grant order, result values and ACK timing from a small model.
module tb_kv_arbiter;

   localparam int TO = 8;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;
   always #5 sys_clk = ~sys_clk;

   logic [1:0]  stb  = 2'b00;
   logic [1:0]  we   = 2'b00;
   logic [1:0]  akey = 2'b00;
   logic [1:0]  dkey = 2'b00;
   logic [15:0] adr  [2];
   logic [15:0] wdat [2];
   logic        m_ack = 1'b0, m_dup = 1'b0, m_stall = 1'b0;
   logic [15:0] m_rdat = 16'h0;

   wire [1:0]  ack, dup_o, err_o, stall_o;
   wire [15:0] rdat [2];
   wire        m_stb, m_cyc, m_we, m_akey, m_dkey, m_abort;
   wire [15:0] m_adr, m_wdat;

   kv_arbiter #(.TIMEOUT(TO)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .R0_STB_i(stb[0]), .R0_WE_i(we[0]), .R0_ADR_i(adr[0]), .R0_DAT_i(wdat[0]),
      .R0_ADR_IS_KEY_i(akey[0]), .R0_DAT_IS_KEY_i(dkey[0]),
      .R0_ACK_o(ack[0]), .R0_DAT_o(rdat[0]), .R0_DUP_o(dup_o[0]), .R0_ERR_o(err_o[0]),
      .R0_STALL_o(stall_o[0]),
      .R1_STB_i(stb[1]), .R1_WE_i(we[1]), .R1_ADR_i(adr[1]), .R1_DAT_i(wdat[1]),
      .R1_ADR_IS_KEY_i(akey[1]), .R1_DAT_IS_KEY_i(dkey[1]),
      .R1_ACK_o(ack[1]), .R1_DAT_o(rdat[1]), .R1_DUP_o(dup_o[1]), .R1_ERR_o(err_o[1]),
      .R1_STALL_o(stall_o[1]),
      .M_STB_o(m_stb), .M_CYC_o(m_cyc), .M_WE_o(m_we),
      .M_ADR_IS_KEY_o(m_akey), .M_DAT_IS_KEY_o(m_dkey),
      .M_ADR_o(m_adr), .M_DAT_o(m_wdat), .M_ABORT_o(m_abort),
      .M_ACK_i(m_ack), .M_DUP_i(m_dup), .M_STALL_i(m_stall), .M_DAT_i(m_rdat)
   );

   int checks = 0;
   int errors = 0;

   // reference model: last winner and the value each port should be holding
   int          last_m = 1;
   logic [15:0] held_dat [2];
   logic        held_dup [2];
   logic        held_err [2];

   // observations of one store transaction
   int          o_port, o_nack, o_ackc, o_abort_n, o_abortc;
   logic        o_granted, o_both, o_held_ok, o_regrant;
   logic [15:0] o_dat, o_adr, o_wdat;
   logic        o_dup, o_err, o_we, o_akey, o_dkey, o_cyc;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic model_reset();
      last_m = 1;
      for (int p = 0; p < 2; p++) begin
         held_dat[p] = 16'h0;
         held_dup[p] = 1'b0;
         held_err[p] = 1'b0;
      end
   endtask

   task automatic model_result(input int p, input bit to, input logic [15:0] rd, input logic rdup);
      last_m      = p;
      held_dat[p] = to ? 16'h0 : rd;
      held_dup[p] = to ? 1'b0 : rdup;
      held_err[p] = to;
   endtask

   // Acts as the store for one transaction: waits for a grant, ACKs after
   // 'delay' WAIT cycles (first M_STB cycle = 1) and holds M_ACK_i 'hold'
   // extra cycles; drops the STBs in 'drop' in the requester ACK cycle.
   task automatic serve_one(input int delay, input int hold, input logic [15:0] rd,
                            input logic rdup, input logic [1:0] drop);
      int   w;
      logic ma;
      o_port = -1; o_nack = 0; o_ackc = 0; o_abort_n = 0; o_abortc = 0;
      o_both = 1'b0; o_held_ok = 1'b1; o_regrant = 1'b0;
      o_dat = 16'h0; o_dup = 1'b0; o_err = 1'b0;
      w = 0;
      while (m_stb !== 1'b1 && w < 40) begin
         tick();
         w++;
      end
      o_granted = (m_stb === 1'b1);
      if (!o_granted) return;
      o_we = m_we; o_akey = m_akey; o_dkey = m_dkey; o_adr = m_adr; o_wdat = m_wdat; o_cyc = m_cyc;
      for (int c = 1; c <= 100; c++) begin
         if (m_stb === 1'b1) begin
            if (o_port >= 0) o_regrant = 1'b1;
            if (m_we !== o_we || m_adr !== o_adr || m_wdat !== o_wdat ||
                m_akey !== o_akey || m_dkey !== o_dkey || m_cyc !== 1'b1)
               o_held_ok = 1'b0;
         end
         if (ack[0] === 1'b1 && ack[1] === 1'b1) o_both = 1'b1;
         for (int p = 0; p < 2; p++) begin
            if (ack[p] === 1'b1) begin
               o_nack++;
               if (o_port < 0) begin
                  o_port = p; o_ackc = c;
                  o_dat = rdat[p]; o_dup = dup_o[p]; o_err = err_o[p];
                  stb = stb & ~drop;
               end
            end
         end
         if (m_abort === 1'b1) begin
            o_abort_n++;
            o_abortc = c;
         end
         ma     = (c - 1 >= delay) && (c - 1 <= delay + hold);
         m_ack  = ma;
         m_rdat = ma ? rd : 16'h0;
         m_dup  = ma ? rdup : 1'b0;
         if (o_port >= 0 && !ma) break;
         tick();
      end
      m_ack = 1'b0; m_rdat = 16'h0; m_dup = 1'b0;
   endtask

   task automatic set_req(input int p, input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic ak, input logic dk);
      we[p] = w; adr[p] = a; wdat[p] = d; akey[p] = ak; dkey[p] = dk;
   endtask

   task automatic test_reset();
      model_reset();
      set_req(0, 1'b0, 16'h1000, 16'h1111, 1'b0, 1'b0);
      set_req(1, 1'b1, 16'h2000, 16'h2222, 1'b1, 1'b0);
      stb = 2'b11;
      tick();
      tick();
      checks++;
      if ({ack, dup_o, err_o, stall_o, rdat[0], rdat[1], m_stb, m_cyc, m_we, m_akey, m_dkey,
           m_adr, m_wdat, m_abort} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ack=%b stall=%b m_stb=%b r0dat=%h expected all zero",
                  ack, stall_o, m_stb, rdat[0]);
      end
      sys_rst_n = 1'b1;
      tick();
      checks++;
      if (m_stb !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_edge_grant: m_stb=%b expected 0", m_stb);
      end
   endtask

   task automatic test_round_robin();
      int exp_p;
      for (int i = 0; i < 4; i++) begin
         exp_p = (last_m == 0) ? 1 : 0;
         serve_one(i, 0, 16'h5A00 + 16'(i), 1'(i % 2), (i == 3) ? 2'b11 : 2'b00);
         checks++;
         if (!o_granted || o_port != exp_p || o_nack != 1 || o_both) begin
            errors++;
            $display("FAIL rr_grant[%0d]: granted=%b port=%0d acks=%0d expected port %0d once",
                     i, o_granted, o_port, o_nack, exp_p);
         end
         checks++;
         if (o_adr !== adr[exp_p] || o_we !== we[exp_p] || o_akey !== akey[exp_p] ||
             o_dat !== 16'h5A00 + 16'(i) || o_dup !== 1'(i % 2) || o_err !== 1'b0 || o_ackc != i + 2) begin
            errors++;
            $display("FAIL rr_data[%0d]: adr=%h dat=%h dup=%b err=%b ackc=%0d expected adr=%h dat=%h ackc=%0d",
                     i, o_adr, o_dat, o_dup, o_err, o_ackc, adr[exp_p], 16'h5A00 + 16'(i), i + 2);
         end
         model_result(exp_p, 1'b0, 16'h5A00 + 16'(i), 1'(i % 2));
      end
   endtask

   task automatic test_single_read();
      set_req(0, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0);
      stb[0] = 1'b1;
      serve_one(4, 0, 16'h00AB, 1'b0, 2'b01);
      checks++;
      if (o_port != 0 || o_nack != 1 || o_dat !== 16'h00AB || o_err !== 1'b0 || o_ackc != 6 ||
          o_adr !== 16'h0003 || o_we !== 1'b0 || o_cyc !== 1'b1 || !o_held_ok) begin
         errors++;
         $display("FAIL single_read: port=%0d dat=%h err=%b ackc=%0d adr=%h held=%b expected 0/00ab/0/6/0003/1",
                  o_port, o_dat, o_err, o_ackc, o_adr, o_held_ok);
      end
      checks++;
      if (rdat[1] !== held_dat[1] || dup_o[1] !== held_dup[1] || err_o[1] !== held_err[1]) begin
         errors++;
         $display("FAIL single_read_r1_untouched: r1 dat=%h expected %h", rdat[1], held_dat[1]);
      end
      model_result(0, 1'b0, 16'h00AB, 1'b0);
   endtask

   task automatic test_timeout();
      tick();
      checks++;
      if (rdat[0] !== held_dat[0]) begin
         errors++;
         $display("FAIL r0_dat_held: got %h expected %h", rdat[0], held_dat[0]);
      end
      set_req(0, 1'b0, 16'h0044, 16'h0000, 1'b1, 1'b0);
      stb[0] = 1'b1;
      serve_one(1000, 0, 16'hFFFF, 1'b1, 2'b01);
      checks++;
      if (o_port != 0 || o_nack != 1 || o_err !== 1'b1 || o_dat !== 16'h0 || o_dup !== 1'b0 ||
          o_ackc != TO + 1) begin
         errors++;
         $display("FAIL timeout_result: port=%0d err=%b dat=%h ackc=%0d expected 0/1/0000/%0d",
                  o_port, o_err, o_dat, o_ackc, TO + 1);
      end
      checks++;
      if (o_abort_n != 1 || o_abortc != TO + 1) begin
         errors++;
         $display("FAIL timeout_abort: pulses=%0d at=%0d expected 1 at %0d", o_abort_n, o_abortc, TO + 1);
      end
      model_result(0, 1'b1, 16'h0, 1'b0);
   endtask

   task automatic test_drain();
      set_req(1, 1'b1, 16'h0F0F, 16'hBEEF, 1'b1, 1'b0);
      set_req(0, 1'b0, 16'h0101, 16'h0000, 1'b0, 1'b1);
      stb = 2'b11;
      serve_one(2, 3, 16'hC0DE, 1'b1, 2'b10);
      checks++;
      if (o_port != 1 || o_nack != 1 || o_regrant || o_dat !== 16'hC0DE || o_dup !== 1'b1 ||
          o_ackc != 4 || o_wdat !== 16'hBEEF || o_we !== 1'b1 || o_akey !== 1'b1) begin
         errors++;
         $display("FAIL drain_ack: port=%0d acks=%0d regrant=%b dat=%h ackc=%0d expected 1/1/0/c0de/4",
                  o_port, o_nack, o_regrant, o_dat, o_ackc);
      end
      model_result(1, 1'b0, 16'hC0DE, 1'b1);
      tick();
      checks++;
      if (m_stb !== 1'b0) begin
         errors++;
         $display("FAIL drain_early_grant: m_stb=%b expected 0", m_stb);
      end
      tick();
      checks++;
      if (m_stb !== 1'b1 || m_adr !== 16'h0101 || m_dkey !== 1'b1) begin
         errors++;
         $display("FAIL drain_next_grant: m_stb=%b adr=%h expected 1/0101", m_stb, m_adr);
      end
      serve_one(0, 0, 16'h0001, 1'b0, 2'b01);
      checks++;
      if (o_port != 0 || o_ackc != 2 || o_dat !== 16'h0001) begin
         errors++;
         $display("FAIL back_to_back: port=%0d ackc=%0d dat=%h expected 0/2/0001", o_port, o_ackc, o_dat);
      end
      model_result(0, 1'b0, 16'h0001, 1'b0);
   endtask

   task automatic test_stall();
      m_stall = 1'b1;
      set_req(0, 1'b1, 16'h0555, 16'h4321, 1'b0, 1'b0);
      stb[0] = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (m_stb !== 1'b0 || stall_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL store_stall: m_stb=%b r0_stall=%b expected 0/1", m_stb, stall_o[0]);
      end
      m_stall = 1'b0;
      #1;
      checks++;
      if (stall_o !== 2'b10) begin
         errors++;
         $display("FAIL stall_comb: stall=%b expected 10", stall_o);
      end
      serve_one(3, 0, 16'h4444, 1'b0, 2'b01);
      checks++;
      if (o_port != 0 || o_ackc != 5 || o_dat !== 16'h4444 || o_wdat !== 16'h4321) begin
         errors++;
         $display("FAIL stall_release: port=%0d ackc=%0d dat=%h expected 0/5/4444", o_port, o_ackc, o_dat);
      end
      model_result(0, 1'b0, 16'h4444, 1'b0);
   endtask

   task automatic test_reset_mid();
      int w;
      set_req(0, 1'b0, 16'h0E0E, 16'h0000, 1'b0, 1'b0);
      stb[0] = 1'b1;
      w = 0;
      while (m_stb !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      checks++;
      if (m_stb !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_grant: m_stb=%b expected 1", m_stb);
      end
      tick(); tick();
      #1;
      sys_rst_n = 1'b0;
      #1;
      checks++;
      if ({ack, dup_o, err_o, stall_o, rdat[0], rdat[1], m_stb, m_cyc, m_we, m_akey, m_dkey,
           m_adr, m_wdat, m_abort} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: ack=%b m_stb=%b r0dat=%h r1dat=%h expected all zero",
                  ack, m_stb, rdat[0], rdat[1]);
      end
      model_reset();
      tick(); tick();
      checks++;
      if (ack !== 2'b00 || m_abort !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_no_ack: ack=%b abort=%b expected 00/0", ack, m_abort);
      end
      set_req(0, 1'b0, 16'h0A0A, 16'h0000, 1'b0, 1'b0);
      set_req(1, 1'b0, 16'h0B0B, 16'h0000, 1'b0, 1'b0);
      stb = 2'b11;
      sys_rst_n = 1'b1;
      serve_one(1, 0, 16'h3333, 1'b0, 2'b11);
      checks++;
      if (o_port != 0 || o_adr !== 16'h0A0A || o_dat !== 16'h3333) begin
         errors++;
         $display("FAIL reset_mid_first_grant: port=%0d adr=%h expected 0/0a0a", o_port, o_adr);
      end
      model_result(0, 1'b0, 16'h3333, 1'b0);
   endtask

   task automatic test_random();
      logic [1:0]  pend;
      int          exp_p, delay, hold, exp_ackc;
      logic [15:0] rd;
      logic        rdup;
      bit          to;
      pend = 2'b00;
      for (int it = 0; it < 40; it++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && ($urandom_range(0, 1) == 1 || pend == 2'b00)) begin
               set_req(p, 1'($urandom_range(0, 1)), 16'($urandom()), 16'($urandom()),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
               pend[p] = 1'b1;
               stb[p]  = 1'b1;
            end
         end
         exp_p    = (pend == 2'b11) ? ((last_m == 0) ? 1 : 0) : (pend[1] ? 1 : 0);
         delay    = $urandom_range(0, TO + 1);
         hold     = $urandom_range(0, 2);
         rd       = 16'($urandom());
         rdup     = 1'($urandom_range(0, 1));
         to       = (delay >= TO);
         exp_ackc = to ? TO + 1 : delay + 2;
         serve_one(delay, hold, rd, rdup, 2'b01 << exp_p);
         checks++;
         if (!o_granted || o_port != exp_p || o_nack != 1 || o_both || o_regrant || o_ackc != exp_ackc) begin
            errors++;
            $display("FAIL rand_grant[%0d]: port=%0d acks=%0d ackc=%0d expected port %0d ackc %0d",
                     it, o_port, o_nack, o_ackc, exp_p, exp_ackc);
         end
         checks++;
         if (o_adr !== adr[exp_p] || o_wdat !== wdat[exp_p] || o_we !== we[exp_p] ||
             o_akey !== akey[exp_p] || o_dkey !== dkey[exp_p] || !o_held_ok) begin
            errors++;
            $display("FAIL rand_store_fields[%0d]: adr=%h dat=%h held=%b expected adr=%h dat=%h",
                     it, o_adr, o_wdat, o_held_ok, adr[exp_p], wdat[exp_p]);
         end
         checks++;
         if (o_dat !== (to ? 16'h0 : rd) || o_dup !== (to ? 1'b0 : rdup) || o_err !== 1'(to) ||
             o_abort_n != (to ? 1 : 0)) begin
            errors++;
            $display("FAIL rand_result[%0d]: dat=%h dup=%b err=%b aborts=%0d expected dat=%h err=%0d",
                     it, o_dat, o_dup, o_err, o_abort_n, to ? 16'h0 : rd, to);
         end
         checks++;
         if (rdat[1-exp_p] !== held_dat[1-exp_p] || dup_o[1-exp_p] !== held_dup[1-exp_p] ||
             err_o[1-exp_p] !== held_err[1-exp_p]) begin
            errors++;
            $display("FAIL rand_other_port[%0d]: dat=%h expected %h", it, rdat[1-exp_p], held_dat[1-exp_p]);
         end
         model_result(exp_p, to, rd, rdup);
         pend[exp_p] = 1'b0;
      end
      stb = 2'b00;
   endtask

   initial begin
      adr[0] = 16'h0; adr[1] = 16'h0; wdat[0] = 16'h0; wdat[1] = 16'h0;
      test_reset();
      test_round_robin();
      test_single_read();
      test_timeout();
      test_drain();
      test_stall();
      test_reset_mid();
      test_random();
      tick(); tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/kv_arbiter.md
KV_ARBITER -- requirements
Module: kv_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, WAIT-state cycles without store ACK before abort; legal 2..255.
REQ-002 sys_clk  in  1  sole clock, all state on rising edge.
REQ-003 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Rn_STB_i (n=0,1)  in  1  requester n strobe; held with fields until Rn_ACK_o.
REQ-005 Rn_WE_i  in  1  1=write, 0=read.
REQ-006 Rn_ADR_i / Rn_DAT_i  in  16 each  address/key and data/value.
REQ-007 Rn_ADR_IS_KEY_i / Rn_DAT_IS_KEY_i  in  1 each  operand-type flags.
REQ-008 Rn_ACK_o  out  1  one-cycle completion pulse.
REQ-009 Rn_DAT_o  out  16  read/write result, valid with Rn_ACK_o, held until next ACK to n.
REQ-010 Rn_DUP_o / Rn_ERR_o  out  1 each  store duplicate flag / timeout flag, valid with Rn_ACK_o.
REQ-011 Rn_STALL_o  out  1  requester n not being served.
REQ-012 M_STB_o, M_CYC_o, M_WE_o, M_ADR_IS_KEY_o, M_DAT_IS_KEY_o  out  1 each  store-side request.
REQ-013 M_ADR_o / M_DAT_o  out  16 each  store address/data.
REQ-014 M_ABORT_o  out  1  one-cycle pulse to the store's synchronous abort input.
REQ-015 M_ACK_i, M_DUP_i, M_STALL_i  in  1 each; M_DAT_i  in  16  store response.

Function
REQ-016 FSM states IDLE, WAIT, DRAIN; reset state IDLE.
REQ-017 IDLE: if any Rn_STB_i=1 and M_STALL_i=0, grant one port, register its WE/ADR/DAT/flags onto M_*, set M_STB_o=M_CYC_o=1, clear timeout counter, go WAIT.
REQ-018 Round-robin: both requesting -> grant port != last_grant; one requesting -> that port; last_grant updates at each grant.
REQ-019 WAIT: M_* held constant; counter increments each cycle (8-bit, saturating).
REQ-020 WAIT with M_ACK_i=1: Rg_DAT_o<=M_DAT_i, Rg_DUP_o<=M_DUP_i, Rg_ERR_o<=0, Rg_ACK_o=1 for next cycle only, M_STB_o<=0, M_CYC_o<=0, go DRAIN.
REQ-021 WAIT with counter=TIMEOUT-1 and M_ACK_i=0: Rg_DAT_o<=0, Rg_DUP_o<=0, Rg_ERR_o<=1, Rg_ACK_o pulse, M_ABORT_o pulse one cycle, M_STB_o<=0, go DRAIN; ACK same cycle as timeout wins (normal completion).
REQ-022 DRAIN: stay while M_ACK_i=1; M_ACK_i=0 -> IDLE; minimum one cycle, so min request-to-ACK latency is 2 cycles and back-to-back grants are >=3 cycles apart.
REQ-023 Rn_STALL_o = 1 unless state=IDLE and port n would be granted this cycle (combinational).
REQ-024 Requester STB high in the ACK cycle is ignored; STB high on return to IDLE is a new request.
REQ-025 Non-granted port's outputs unchanged; Rn_ACK_o never asserted for both ports at once.

Reset
REQ-026 Asserting sys_rst_n=0 at any time: state IDLE, last_grant=1 (port 0 wins first), counter 0, all outputs 0, in-flight request dropped without ACK.
REQ-027 Reset release is synchronised internally; first grant no earlier than the second sys_clk edge after release.

Structure
REQ-028 Shared package kv_pkg: FSM state enum, KV_W=16 data width, TIMEOUT default.
REQ-029 Sub-module kv_rr_arbiter: 2-way round-robin picker (req[1:0], last_grant -> gnt one-hot).

Verification
REQ-030 R0 read ADR=3, store ACKs after 4 cycles with M_DAT_i=0x00AB -> R0_ACK_o pulse, R0_DAT_o=0x00AB, R0_ERR_o=0, R1 untouched.
REQ-031 R0 and R1 both assert STB from reset -> grants R0, R1, R0, R1; each port ACKed exactly once per request.
REQ-032 Read, store never ACKs, TIMEOUT=8 -> R0_ACK_o and R0_ERR_o on cycle 8 of WAIT, M_ABORT_o one pulse, R0_DAT_o=0.
REQ-033 Store holds M_ACK_i high 3 cycles after ACK -> DRAIN 3 cycles, no second ACK, next grant after M_ACK_i falls.
REQ-034 sys_rst_n low mid-WAIT -> all outputs 0 immediately, no ACK; after release R0 granted first.
